// File: rtl/placement_checker_if.sv
// Interface between the placement checker and its environment: start/status/results
// plus the read ports of the pos_X/pos_Y/grid RAMs and the edge ROMs.
interface placement_checker_if #(
  parameter int W = 32
) ();
  logic         start;
  logic         busy;
  logic         done;
  logic         pass;
  logic [2:0]   err_code;
  logic [W-1:0] err_index;
  logic [W-1:0] cost;
  logic [W-1:0] cost_1hop;

  logic         edge_re;
  logic [W-1:0] edge_addr;
  logic [W-1:0] edge_a;
  logic [W-1:0] edge_b;

  logic         pos_re;
  logic [W-1:0] pos_addr;
  logic [W-1:0] pos_x;
  logic [W-1:0] pos_y;

  logic         grid_re;
  logic [W-1:0] grid_addr;
  logic [W-1:0] grid_data;

  // master: the checker itself; slave: the surrounding system and memories
  modport master (
    input  start, edge_a, edge_b, pos_x, pos_y, grid_data,
    output busy, done, pass, err_code, err_index, cost, cost_1hop,
           edge_re, edge_addr, pos_re, pos_addr, grid_re, grid_addr
  );

  modport slave (
    output start, edge_a, edge_b, pos_x, pos_y, grid_data,
    input  busy, done, pass, err_code, err_index, cost, cost_1hop,
           edge_re, edge_addr, pos_re, pos_addr, grid_re, grid_addr
  );
endinterface

// File: rtl/placement_checker.sv
// Post-placement verifier: checks every node is placed, in bounds and grid-consistent,
// then sums wirelength and 1-hop cost over all edges. Memories have 2-cycle read latency.
module placement_checker #(
  parameter int N_NODES  = 10,
  parameter int GRID_DIM = 10,
  parameter int N_EDGE   = 96,
  parameter int W        = 32
) (
  input  logic                clk,
  input  logic                reset,
  placement_checker_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_N_RD, S_N_WAIT, S_N_CHK, S_G_WAIT, S_G_CHK,
    S_E_RD, S_E_WAIT, S_E_CHK, S_PA_WAIT, S_PA_LAT, S_PB_WAIT, S_PB_LAT,
    S_ACC, S_FIN, S_DONE
  } state_t;

  localparam logic [W-1:0]        L_N_NODES = W'(N_NODES);
  localparam logic [W-1:0]        L_N_EDGE  = W'(N_EDGE);
  localparam logic [W-1:0]        L_GRID_U  = W'(GRID_DIM);
  localparam logic signed [W-1:0] L_GRID_S  = W'(GRID_DIM);
  localparam logic [W-1:0]        L_ONE     = W'(1);

  state_t       r_state;
  logic         r_busy, r_done, r_pass;
  logic [2:0]   r_err_code;
  logic [W-1:0] r_err_index, r_cost, r_cost_1hop;
  logic         r_edge_re, r_pos_re, r_grid_re;
  logic [W-1:0] r_edge_addr, r_pos_addr, r_grid_addr;
  logic [W-1:0] r_node, r_edge, r_id_b;
  logic [W-1:0] r_xa, r_ya, r_dx, r_dy;

  logic         w_unplaced, w_out_of_bounds, w_edge_bad;
  logic [W-1:0] w_grid_addr, w_node_next, w_edge_next;
  logic [W-1:0] w_dx_diff, w_dy_diff, w_dx, w_dy;
  logic [W-1:0] w_cost_inc, w_hop_inc;

  assign w_unplaced      = (bus.pos_x == '1) || (bus.pos_y == '1);
  assign w_out_of_bounds = ($signed(bus.pos_x) < 0) || ($signed(bus.pos_x) >= L_GRID_S) ||
                           ($signed(bus.pos_y) < 0) || ($signed(bus.pos_y) >= L_GRID_S);
  assign w_grid_addr     = bus.pos_x * L_GRID_U + bus.pos_y;
  assign w_node_next     = r_node + L_ONE;
  assign w_edge_next     = r_edge + L_ONE;
  assign w_edge_bad      = (bus.edge_a >= L_N_NODES) || (bus.edge_b >= L_N_NODES);

  // Distances use wrapping two's-complement subtraction, then negate if negative
  assign w_dx_diff  = r_xa - bus.pos_x;
  assign w_dy_diff  = r_ya - bus.pos_y;
  assign w_dx       = w_dx_diff[W-1] ? -w_dx_diff : w_dx_diff;
  assign w_dy       = w_dy_diff[W-1] ? -w_dy_diff : w_dy_diff;
  assign w_cost_inc = r_dx + r_dy - L_ONE;
  assign w_hop_inc  = (r_dx >> 1) + W'(r_dx[0]) + (r_dy >> 1) + W'(r_dy[0]) - L_ONE;

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_code  <= '0;
      r_err_index <= '0;
      r_cost      <= '0;
      r_cost_1hop <= '0;
      r_edge_re   <= 1'b0;
      r_pos_re    <= 1'b0;
      r_grid_re   <= 1'b0;
      r_edge_addr <= '0;
      r_pos_addr  <= '0;
      r_grid_addr <= '0;
      r_node      <= '0;
      r_edge      <= '0;
      r_id_b      <= '0;
      r_xa        <= '0;
      r_ya        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
    end else begin
      // NOTE: read enables default low so each request is a single-cycle pulse.
      r_edge_re <= 1'b0;
      r_pos_re  <= 1'b0;
      r_grid_re <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_code  <= '0;
            r_err_index <= '0;
            r_cost      <= '0;
            r_cost_1hop <= '0;
            r_node      <= '0;
            r_edge      <= '0;
            if (N_NODES > 0)     r_state <= S_N_RD;
            else if (N_EDGE > 0) r_state <= S_E_RD;
            else                 r_state <= S_FIN;
          end
        end

        S_N_RD: begin
          r_pos_re   <= 1'b1;
          r_pos_addr <= r_node;
          r_state    <= S_N_WAIT;
        end
        S_N_WAIT: r_state <= S_N_CHK;
        S_N_CHK: begin
          if (w_unplaced) begin
            r_err_code  <= 3'd1;
            r_err_index <= r_node;
            r_state     <= S_FIN;
          end else if (w_out_of_bounds) begin
            r_err_code  <= 3'd2;
            r_err_index <= r_node;
            r_state     <= S_FIN;
          end else begin
            r_grid_re   <= 1'b1;
            r_grid_addr <= w_grid_addr;
            r_state     <= S_G_WAIT;
          end
        end
        S_G_WAIT: r_state <= S_G_CHK;
        S_G_CHK: begin
          if (bus.grid_data != r_node) begin
            r_err_code  <= 3'd3;
            r_err_index <= r_node;
            r_state     <= S_FIN;
          end else if (w_node_next == L_N_NODES) begin
            r_edge  <= '0;
            r_state <= (N_EDGE > 0) ? S_E_RD : S_FIN;
          end else begin
            r_node  <= w_node_next;
            r_state <= S_N_RD;
          end
        end

        S_E_RD: begin
          r_edge_re   <= 1'b1;
          r_edge_addr <= r_edge;
          r_state     <= S_E_WAIT;
        end
        S_E_WAIT: r_state <= S_E_CHK;
        S_E_CHK: begin
          if (w_edge_bad) begin
            r_err_code  <= 3'd4;
            r_err_index <= r_edge;
            r_state     <= S_FIN;
          end else begin
            r_id_b     <= bus.edge_b;
            r_pos_re   <= 1'b1;
            r_pos_addr <= bus.edge_a;
            r_state    <= S_PA_WAIT;
          end
        end
        S_PA_WAIT: r_state <= S_PA_LAT;
        S_PA_LAT: begin
          r_xa       <= bus.pos_x;
          r_ya       <= bus.pos_y;
          r_pos_re   <= 1'b1;
          r_pos_addr <= r_id_b;
          r_state    <= S_PB_WAIT;
        end
        S_PB_WAIT: r_state <= S_PB_LAT;
        S_PB_LAT: begin
          r_dx    <= w_dx;
          r_dy    <= w_dy;
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_cost      <= r_cost + w_cost_inc;
          r_cost_1hop <= r_cost_1hop + w_hop_inc;
          r_edge      <= w_edge_next;
          r_state     <= (w_edge_next == L_N_EDGE) ? S_FIN : S_E_RD;
        end

        S_FIN: begin
          r_pass  <= (r_err_code == 3'd0);
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_code  = r_err_code;
  assign bus.err_index = r_err_index;
  assign bus.cost      = r_cost;
  assign bus.cost_1hop = r_cost_1hop;
  assign bus.edge_re   = r_edge_re;
  assign bus.edge_addr = r_edge_addr;
  assign bus.pos_re    = r_pos_re;
  assign bus.pos_addr  = r_pos_addr;
  assign bus.grid_re   = r_grid_re;
  assign bus.grid_addr = r_grid_addr;

endmodule
